// File: rtl/rsa_lcl_host.sv
// rsa_lcl_host: packs a 96-word host operand stream into six 512-bit local-bus
// beats, captures the two-beat result and streams it back out as 32 words.
module rsa_lcl_host #(
  parameter int LCL_W  = 512,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [LCL_W-1:0]  lcl_dout,
  output logic              lcl_dv,
  input  logic [LCL_W-1:0]  lcl_din,
  input  logic              lcl_den,
  output logic              lcl_idone,
  output logic              busy,
  output logic              err_den
);

  localparam int WPB    = LCL_W / WORD_W;
  localparam int WC_W   = $clog2(WPB);
  localparam int RWORDS = 2 * LCL_W / WORD_W;
  localparam int RC_W   = $clog2(RWORDS);
  localparam int WSH    = $clog2(WORD_W);
  localparam int NBEATS = 6;

  typedef enum logic [2:0] {IDLE, FILL, SEND, WAIT_RES, CAP1, ACK, DRAIN} state_t;

  state_t                    state;
  logic [LCL_W-1:0]          pack;
  logic [2*LCL_W-1:0]        res;
  logic [WC_W-1:0]           word_cnt;
  logic [2:0]                beat_cnt;
  logic [RC_W-1:0]           drain_cnt;
  logic [RC_W-1:0]           drain_nxt;
  logic [$clog2(LCL_W)-1:0]  wr_idx;
  logic [$clog2(2*LCL_W)-1:0] rd_idx;
  logic                      den_q;
  logic                      den_rise;
  logic                      s_fire;
  logic                      m_fire;

  assign den_rise  = lcl_den & ~den_q;
  assign s_fire    = s_valid & s_ready;
  assign m_fire    = m_valid & m_ready;
  assign drain_nxt = drain_cnt + 1'b1;
  assign wr_idx    = {word_cnt, {WSH{1'b0}}};
  assign rd_idx    = {drain_nxt, {WSH{1'b0}}};
  // The pack register is driven straight out; the receiver samples it only on lcl_dv.
  assign lcl_dout  = pack;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pack      <= '0;
      res       <= '0;
      word_cnt  <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      den_q     <= 1'b0;
      s_ready   <= 1'b0;
      lcl_dv    <= 1'b0;
      lcl_idone <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      err_den   <= 1'b0;
    end else begin
      den_q     <= lcl_den;
      lcl_dv    <= 1'b0;
      lcl_idone <= 1'b0;
      // Only a fresh rising edge outside WAIT_RES counts as unexpected.
      if (den_rise && state != WAIT_RES) err_den <= 1'b1;
      unique case (state)
        IDLE, FILL: begin
          s_ready <= 1'b1;
          if (s_fire) begin
            pack[wr_idx +: WORD_W] <= s_data;
            word_cnt <= word_cnt + 1'b1;
            state    <= FILL;
            if (word_cnt == WC_W'(WPB - 1)) begin
              state   <= SEND;
              s_ready <= 1'b0;
              lcl_dv  <= 1'b1;
            end
          end
        end
        SEND: begin
          if (beat_cnt == 3'(NBEATS - 1)) begin
            beat_cnt <= '0;
            state    <= WAIT_RES;
          end else begin
            beat_cnt <= beat_cnt + 3'd1;
            s_ready  <= 1'b1;
            state    <= FILL;
          end
        end
        WAIT_RES: begin
          if (den_rise) begin
            res[LCL_W-1:0] <= lcl_din;
            state          <= CAP1;
          end
        end
        CAP1: begin
          res[2*LCL_W-1:LCL_W] <= lcl_din;
          lcl_idone            <= 1'b1;
          state                <= ACK;
        end
        ACK: begin
          m_valid   <= 1'b1;
          m_data    <= res[WORD_W-1:0];
          drain_cnt <= '0;
          state     <= DRAIN;
        end
        DRAIN: begin
          if (m_fire) begin
            drain_cnt <= drain_nxt;
            if (drain_cnt == RC_W'(RWORDS - 1)) begin
              m_valid <= 1'b0;
              m_data  <= '0;
              s_ready <= 1'b1;
              state   <= IDLE;
            end else begin
              m_data <= res[rd_idx +: WORD_W];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_lcl_host.sv
// tb_rsa_lcl_host: randomized bench checking rsa_lcl_host against a word-list
// model of beat packing, result capture timing and result draining.
module tb_rsa_lcl_host;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  s_data = '0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [31:0]  m_data;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [511:0] lcl_dout;
  logic         lcl_dv;
  logic [511:0] lcl_din = '0;
  logic         lcl_den = 1'b0;
  logic         lcl_idone;
  logic         busy;
  logic         err_den;

  rsa_lcl_host dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .lcl_dout(lcl_dout), .lcl_dv(lcl_dv),
    .lcl_din(lcl_din), .lcl_den(lcl_den), .lcl_idone(lcl_idone),
    .busy(busy), .err_den(err_den)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  logic [31:0]  op_words [96];
  logic [511:0] res_b0, res_b1;
  logic [511:0] cap_beat [6];
  logic [31:0]  cap_res [32];
  logic [31:0]  held;
  int dv_seen, rd_seen, idone_cnt, idone_cyc, first_mv_cyc, last_mv_cyc, last_dv_cyc, rise_cyc;
  bit gap_check, hold_pending, mv_started;

  task automatic check_output(string name, logic [511:0] act, logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] v = '0;
    for (int i = 0; i < 16; i++) v = {v[479:0], $urandom()};
    return v;
  endfunction

  // Beat b holds words 16b..16b+15, lowest word in the lowest bits.
  function automatic logic [511:0] exp_beat(int b);
    logic [511:0] v = '0;
    for (int i = 15; i >= 0; i--) v = {v[479:0], op_words[16*b+i]};
    return v;
  endfunction

  function automatic logic [31:0] exp_word(int j);
    logic [1023:0] r = {res_b1, res_b0};
    logic [1023:0] s = r >> (32 * j);
    return s[31:0];
  endfunction

  // Single compare process: every output event is checked against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      if (lcl_dv) begin
        if (dv_seen < 6) begin
          check_output("beat", lcl_dout, exp_beat(dv_seen));
          cap_beat[dv_seen] = lcl_dout;
          if (gap_check && dv_seen > 0) check_output("beat_gap", 512'(cyc - last_dv_cyc), 512'd17);
        end else begin
          check_output("dv_count", 512'(dv_seen + 1), 512'd6);
        end
        last_dv_cyc = cyc;
        dv_seen++;
      end
      if (lcl_idone) begin
        idone_cnt++;
        idone_cyc = cyc;
      end
      if (m_valid) begin
        if (hold_pending) check_output("m_hold", {480'b0, m_data}, {480'b0, held});
        if (rd_seen < 32) begin
          check_output("m_data", {480'b0, m_data}, {480'b0, exp_word(rd_seen)});
          if (m_ready) cap_res[rd_seen] = m_data;
        end else begin
          check_output("mv_count", 512'(rd_seen + 1), 512'd32);
        end
        if (!mv_started) begin
          first_mv_cyc = cyc;
          mv_started = 1'b1;
        end
        hold_pending = !m_ready;
        held = m_data;
        if (m_ready) begin
          last_mv_cyc = cyc;
          rd_seen++;
        end
      end else begin
        hold_pending = 1'b0;
      end
    end
  end

  task automatic new_op(bit fixed);
    for (int k = 0; k < 96; k++) op_words[k] = fixed ? 32'(k) : $urandom();
    res_b0 = fixed ? {16{32'hAAAAAAAA}} : rand512();
    res_b1 = fixed ? {16{32'h55555555}} : rand512();
    dv_seen = 0; rd_seen = 0; idone_cnt = 0;
    idone_cyc = -100; first_mv_cyc = -100; last_mv_cyc = -100; last_dv_cyc = 0;
    mv_started = 1'b0; hold_pending = 1'b0;
  endtask

  // Present words lo..hi in order; with bp set, random idle gaps carry junk data.
  task automatic apply_stimulus(int lo, int hi, bit bp);
    int acc = 0;
    for (int k = lo; k <= hi; k++) begin
      if (bp) begin
        repeat ($urandom_range(0, 2)) begin
          s_valid = 1'b0;
          s_data = $urandom();
          @(posedge clk); #1;
        end
      end
      s_valid = 1'b1;
      s_data = op_words[k];
      for (int w = 0; w < 200; w++) begin
        @(negedge clk);
        if (s_ready) begin
          acc++;
          break;
        end
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    check_output("words_accepted", 512'(acc), 512'(hi - lo + 1));
  endtask

  task automatic wait_beats(int n);
    for (int i = 0; i < 3000 && dv_seen < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic drive_result(bit keep_high);
    lcl_den = 1'b1;
    lcl_din = res_b0;
    @(negedge clk);
    rise_cyc = cyc;
    @(posedge clk); #1;
    lcl_din = res_b1;
    @(posedge clk); #1;
    lcl_din = rand512();
    if (!keep_high) begin
      @(posedge clk); #1;
      lcl_den = 1'b0;
    end
  endtask

  task automatic wait_drain(bit bp);
    for (int i = 0; i < 4000 && rd_seen < 32; i++) begin
      m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic end_checks(bit bp);
    @(negedge clk);
    check_output("dv_total", 512'(dv_seen), 512'd6);
    check_output("rd_total", 512'(rd_seen), 512'd32);
    check_output("idone_count", 512'(idone_cnt), 512'd1);
    check_output("idone_latency", 512'(idone_cyc - rise_cyc), 512'd2);
    check_output("mvalid_latency", 512'(first_mv_cyc - rise_cyc), 512'd3);
    if (!bp) check_output("drain_span", 512'(last_mv_cyc - first_mv_cyc), 512'd31);
    check_output("idle_busy", 512'(busy), 512'd0);
    check_output("idle_ready", 512'(s_ready), 512'd1);
    check_output("idle_mvalid", 512'(m_valid), 512'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset();
    check_output("rst_s_ready", 512'(s_ready), 512'd0);
    check_output("rst_lcl_dout", lcl_dout, 512'd0);
    check_output("rst_lcl_dv", 512'(lcl_dv), 512'd0);
    check_output("rst_lcl_idone", 512'(lcl_idone), 512'd0);
    check_output("rst_m_valid", 512'(m_valid), 512'd0);
    check_output("rst_m_data", 512'(m_data), 512'd0);
    check_output("rst_busy", 512'(busy), 512'd0);
    check_output("rst_err_den", 512'(err_den), 512'd0);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_output("ready_after_reset", 512'(s_ready), 512'd1);
    check_output("busy_after_reset", 512'(busy), 512'd0);
    @(posedge clk); #1;

    // Back-to-back counting words with the fixed A/5 result.
    new_op(1'b1);
    gap_check = 1'b1;
    m_ready = 1'b1;
    apply_stimulus(0, 95, 1'b0);
    wait_beats(6);
    drive_result(1'b0);
    wait_drain(1'b0);
    end_checks(1'b0);
    check_output("beat0_word0", {480'b0, cap_beat[0][31:0]}, 512'd0);
    check_output("beat0_word15", {480'b0, cap_beat[0][511:480]}, 512'd15);
    check_output("beat5_word15", {480'b0, cap_beat[5][511:480]}, 512'd95);
    check_output("res_word0", {480'b0, cap_res[0]}, {480'b0, 32'hAAAAAAAA});
    check_output("res_word15", {480'b0, cap_res[15]}, {480'b0, 32'hAAAAAAAA});
    check_output("res_word16", {480'b0, cap_res[16]}, {480'b0, 32'h55555555});
    check_output("res_word31", {480'b0, cap_res[31]}, {480'b0, 32'h55555555});
    check_output("err_clean", 512'(err_den), 512'd0);

    // Random words under backpressure with a stray lcl_den pulse mid-fill.
    new_op(1'b0);
    gap_check = 1'b0;
    apply_stimulus(0, 19, 1'b1);
    check_output("err_before_glitch", 512'(err_den), 512'd0);
    lcl_den = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    lcl_den = 1'b0;
    @(posedge clk); #1;
    check_output("err_after_glitch", 512'(err_den), 512'd1);
    apply_stimulus(20, 95, 1'b1);
    wait_beats(6);
    check_output("err_sticky", 512'(err_den), 512'd1);
    check_output("no_early_idone", 512'(idone_cnt), 512'd0);
    drive_result(1'b1);
    wait_drain(1'b1);
    end_checks(1'b1);

    // lcl_den is still high from the previous result: no capture until it re-rises.
    new_op(1'b0);
    apply_stimulus(0, 95, 1'b1);
    wait_beats(6);
    repeat (8) @(posedge clk);
    #1;
    check_output("linger_no_idone", 512'(idone_cnt), 512'd0);
    check_output("linger_busy", 512'(busy), 512'd1);
    check_output("linger_no_mvalid", 512'(m_valid), 512'd0);
    lcl_den = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_ready = 1'b1;
    drive_result(1'b0);
    wait_drain(1'b0);
    end_checks(1'b0);

    // Reset after 40 words, then a complete fresh operation.
    new_op(1'b0);
    gap_check = 1'b1;
    apply_stimulus(0, 39, 1'b0);
    #3 rst_n = 1'b0;
    @(negedge clk);
    check_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    new_op(1'b0);
    gap_check = 1'b1;
    apply_stimulus(0, 95, 1'b0);
    wait_beats(6);
    drive_result(1'b0);
    wait_drain(1'b1);
    end_checks(1'b1);
    check_output("err_after_reset_op", 512'(err_den), 512'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rsa_lcl_host.md
# rsa_lcl_host

Host-side bridge for the RSA local-bus link: accepts a 32-bit word stream (key, modulus, data; 1024 bits each), packs it into six 512-bit beats driven on `lcl_dout`/`lcl_dv`, then captures the two 512-bit result beats returned on `lcl_din`/`lcl_den`. It acknowledges the result with a one-cycle `lcl_idone` pulse and streams the 1024-bit result back out as 32 words. It sits between the host DMA/register path and the RSA interface block, and drives the far end of that 512-bit local bus.

## Interface
- `LCL_W`, 512: local-bus beat width. Only the default is supported and verified.
- `WORD_W`, 32: host word width. Only the default is supported and verified.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `s_data` in 32: host input word.
- `s_valid` in 1: `s_data` is valid.
- `s_ready` out 1: block accepts a word. A transfer happens when `s_valid` and `s_ready` are both high.
- `m_data` out 32: result word.
- `m_valid` out 1: `m_data` is valid.
- `m_ready` in 1: host accepts the result word.
- `lcl_dout` out 512: operand beat.
- `lcl_dv` out 1: one-cycle strobe; `lcl_dout` is valid.
- `lcl_din` in 512: result beat.
- `lcl_den` in 1: result-valid level.
- `lcl_idone` out 1: one-cycle result acknowledge.
- `busy` out 1: high whenever the state is not `IDLE`.
- `err_den` out 1: sticky flag, set by an unexpected `lcl_den` rising edge; cleared only by reset.

## Operation
- **Input order:** 96 words, least-significant word first. Words 0–31 are the key, 32–63 the modulus, 64–95 the data.
- **Packing:** word k goes to bits [32·(k mod 16)+31 : 32·(k mod 16)] of beat ⌊k/16⌋. Beats 0–5 are key lo, key hi, mod lo, mod hi, data lo, data hi.
- **FSM states:**
  - `IDLE`/`FILL`: `s_ready`=1. Accepted words are written into the 512-bit pack register, and a 4-bit word counter increments on each accepted word. When the 16th word of a beat is accepted, go to `SEND`.
  - `SEND` (1 cycle): `lcl_dv`=1 and `lcl_dout` is the packed beat; `s_ready`=0; the 3-bit beat counter increments. If beats sent < 6, go to `FILL`; otherwise go to `WAIT_RES`.
  - `WAIT_RES`: `s_ready`=0. On a `lcl_den` rising edge (`lcl_den`=1 with the registered `den_q`=0), capture `lcl_din` into `res[511:0]` and go to `CAP1`.
  - `CAP1` (1 cycle): capture `lcl_din` into `res[1023:512]` unconditionally, whatever the value of `lcl_den`. Go to `ACK`.
  - `ACK` (1 cycle): `lcl_idone`=1. Go to `DRAIN`.
  - `DRAIN`: `m_valid`=1 and `m_data` = `res[32j+31:32j]`. j increments on each handshake. After word 31 is accepted, go to `IDLE`.
- **Unexpected `lcl_den`:** a rising edge in any state other than `WAIT_RES` sets `err_den` and is otherwise ignored.
- **Lingering `lcl_den`:** if `lcl_den` is already high on entry to `WAIT_RES`, it does not count. A fresh rising edge is required.
- **Counters:** all counters wrap to 0 at the end of an operation. No partial-beat flush is performed; a stalled `s_valid` simply holds the FSM in `FILL`.
- **Reset mid-operation:** the FSM returns to `IDLE` immediately and the pack and result buffers clear. In-flight words are lost.

## Timing
- **Reset values:** `s_ready`=0 while `rst_n`=0, and 1 from the first clock in `IDLE`. `lcl_dout`=0, `lcl_dv`=0, `lcl_idone`=0, `m_valid`=0, `m_data`=0, `busy`=0, `err_den`=0.
- All outputs are registered or decoded from registered state.
- **Beat launch:** 16th word accepted at cycle t → `lcl_dv`=1 at t+1 → `s_ready`=1 again at t+2. Best case is one beat per 17 cycles.
- **`lcl_dout` between strobes:** it holds the last beat. Bits of the next beat update as words arrive; the receiver must sample only on `lcl_dv`.
- **Result capture:** `lcl_den` rising edge seen at cycle r → beat 0 captured at r, beat 1 at r+1, `lcl_idone`=1 at r+2, `m_valid`=1 from r+3.
- **After `ACK`:** `lcl_den` is expected to fall within 2 cycles. If it is still high, that is not an error; only rising edges are checked.
- **Drain throughput:** with `m_ready` held high, 32 words take 32 cycles. `m_data` is stable while `m_valid` && !`m_ready`.

## Test plan
- **Packing:** 96 words with value `s_data`=k (k=0..95), sent back-to-back → exactly 6 `lcl_dv` pulses, 17 cycles apart. Beat 0 bits[31:0]=0 and [511:480]=15. Beat 5 bits[511:480]=95.
- **Result path:** drive `lcl_den` rising with `lcl_din`=512'hA…A, then next cycle 512'h5…5 → one `lcl_idone` pulse at r+2. `m_data` words 0–15 = 32'hAAAAAAAA, words 16–31 = 32'h55555555.
- **Backpressure:** toggle `s_valid` and `m_ready` pseudo-randomly → same beats and result words as the back-to-back run. No word is duplicated or dropped. `m_data` is stable while stalled.
- **Unexpected `lcl_den`:** rising edge during `FILL` → `err_den`=1 and sticky. Packing is unaffected, and no `lcl_idone` is issued until a rising edge in `WAIT_RES`.
- **Lingering `lcl_den`:** `lcl_den` held high since the previous operation at entry to `WAIT_RES` → no capture. Drop it, then raise it → normal capture.
- **Reset mid-operation:** assert `rst_n`=0 after 40 words → all outputs at reset values. A full new 96-word operation then completes correctly.
